// File: rtl/uart_pkg.sv
// Constants and types shared by the UART command path.
// Holds the frame opcodes, the response bytes and the command FSM state type.
package uart_pkg;

   localparam int BITWIDTH = 8;
   localparam int SB_TICK  = 16;

   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h4B;
   localparam logic [7:0] RSP_NAK = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      REG_WR,
      REG_RD,
      RD_CAP,
      SEND
   } cmd_state_t;

   function automatic logic is_cmd(input logic [7:0] op);
      return (op == OP_WR) || (op == OP_RD);
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: a saturating counter with synchronous clear and enable.
// The tc output flags the last idle cycle that is allowed before a frame is abandoned.
module uart_cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CNT_W          = 17
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-frame command engine: parses W/R frames from the RX FIFO, drives one register-bus
// beat, and pushes a single response byte into the TX FIFO.
module uart_cmd_ctrl
   import uart_pkg::*;
#(
   parameter int DW             = 8,
   parameter int AW             = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CNT_W          = 17
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [DW-1:0] r_data,
   input  logic          rx_empty,
   output logic          rd_uart,
   output logic [DW-1:0] w_data,
   output logic          wr_uart,
   input  logic          tx_full,
   output logic [AW-1:0] reg_addr,
   output logic [DW-1:0] reg_wdata,
   output logic          reg_we,
   output logic          reg_re,
   input  logic [DW-1:0] reg_rdata,
   output logic          busy,
   output logic          timeout_err
);

   cmd_state_t    state_q, state_d;
   logic [DW-1:0] op_q;
   logic [DW-1:0] resp_q;
   logic          tmo_clr, tmo_en, tmo_tc;

   uart_cmd_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_timeout (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .tc     (tmo_tc)
   );

   always_comb begin
      state_d     = state_q;
      rd_uart     = 1'b0;
      reg_we      = 1'b0;
      reg_re      = 1'b0;
      wr_uart     = 1'b0;
      timeout_err = 1'b0;
      tmo_clr     = 1'b1;
      tmo_en      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_empty) begin
               rd_uart = 1'b1;
               state_d = is_cmd(r_data) ? GET_ADDR : SEND;
            end
         end
         GET_ADDR, GET_DATA: begin
            // The watchdog only runs while waiting for the rest of a frame.
            tmo_clr = 1'b0;
            if (!rx_empty) begin
               rd_uart = 1'b1;
               tmo_clr = 1'b1;
               if (state_q == GET_DATA)
                  state_d = REG_WR;
               else
                  state_d = (op_q == OP_WR) ? GET_DATA : REG_RD;
            end else if (tmo_tc) begin
               timeout_err = 1'b1;
               state_d     = IDLE;
            end else begin
               tmo_en = 1'b1;
            end
         end
         REG_WR: begin
            reg_we  = 1'b1;
            state_d = SEND;
         end
         REG_RD: begin
            reg_re  = 1'b1;
            state_d = RD_CAP;
         end
         RD_CAP: state_d = SEND;
         SEND: begin
            if (!tx_full) begin
               wr_uart = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A reset cycle must never leak a strobe from the frame it is aborting.
      if (!reset_n) begin
         rd_uart     = 1'b0;
         reg_we      = 1'b0;
         reg_re      = 1'b0;
         wr_uart     = 1'b0;
         timeout_err = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         resp_q    <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (rd_uart) begin
                  op_q <= r_data;
                  if (!is_cmd(r_data))
                     resp_q <= DW'(RSP_NAK);
               end
            end
            GET_ADDR: if (rd_uart) reg_addr  <= AW'(r_data);
            GET_DATA: if (rd_uart) reg_wdata <= r_data;
            REG_WR:   resp_q <= DW'(RSP_ACK);
            RD_CAP:   resp_q <= reg_rdata;
            default: ;
         endcase
      end
   end

   assign w_data = resp_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboarded bench for uart_cmd_ctrl: FIFO and register-bus models around the DUT, a
// frame-level reference model feeding expectation queues, and a monitor that checks them.
module tb_uart_cmd_ctrl;

   localparam int TMO = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] r_data = 8'h00;
   logic       rx_empty = 1'b1;
   logic       tx_full = 1'b0;
   logic [7:0] reg_rdata = 8'h00;
   logic       rd_uart, wr_uart, reg_we, reg_re, busy, timeout_err;
   logic [7:0] w_data, reg_addr, reg_wdata;

   always #5 clk = ~clk;

   uart_cmd_ctrl #(.DW(8), .AW(8), .TIMEOUT_CYCLES(TMO), .CNT_W(17)) dut (
      .clk(clk), .reset_n(reset_n), .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
      .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
      .busy(busy), .timeout_err(timeout_err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  rxq[$];
   logic [7:0]  src[$];
   logic [7:0]  mem[256];
   logic [7:0]  ref_mem[256];
   logic [7:0]  exp_rsp[$];
   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];

   int n_chk = 0, n_fail = 0;
   int wr_cnt = 0, we_cnt = 0, re_cnt = 0, tmo_cnt = 0, pop_cnt = 0;
   int last_wr_cyc = -1, last_we_cyc = -1, last_re_cyc = -1, last_tmo_cyc = -1, last_pop_cyc = -1;
   int gap = 0;
   bit rand_gaps = 0, rand_tx = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a strobe.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("pop_while_empty", int'(rd_uart && rx_empty), 0);
         chk("push_while_full", int'(wr_uart && tx_full), 0);
         if (rd_uart) begin pop_cnt++; last_pop_cyc = cyc; end
         if (timeout_err) begin tmo_cnt++; last_tmo_cyc = cyc; end
         if (wr_uart) begin
            wr_cnt++; last_wr_cyc = cyc;
            if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(w_data), -1);
            else chk("rsp_byte", 32'(w_data), 32'(exp_rsp.pop_front()));
         end
         if (reg_we) begin
            we_cnt++; last_we_cyc = cyc;
            if (exp_wr.size() == 0) chk("unexpected_we", 32'({reg_addr, reg_wdata}), -1);
            else chk("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_wr.pop_front()));
         end
         if (reg_re) begin
            re_cnt++; last_re_cyc = cyc;
            if (exp_rd.size() == 0) chk("unexpected_re", 32'(reg_addr), -1);
            else chk("re_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
         end
      end
   end

   // One clock: sample DUT strobes mid-cycle, update FIFO / bus models just after the edge.
   task automatic step();
      logic       p, re;
      logic [7:0] ra;
      @(negedge clk);
      p  = rd_uart;
      re = reg_re;
      ra = reg_addr;
      if (reg_we) mem[reg_addr] = reg_wdata;
      @(posedge clk);
      #1;
      if (p && rxq.size() > 0) void'(rxq.pop_front());
      if (src.size() > 0) begin
         if (gap == 0) begin
            rxq.push_back(src.pop_front());
            gap = rand_gaps ? int'($urandom_range(0, 3)) : 0;
         end else gap--;
      end
      reg_rdata = re ? mem[ra] : 8'($urandom);
      if (rand_tx) tx_full = ($urandom_range(0, 3) == 0);
      rx_empty = (rxq.size() == 0);
      r_data   = rx_empty ? 8'h00 : rxq[0];
   endtask

   // Reference model: what a whole frame must produce, from the frame rules alone.
   task automatic model_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
      if (op == 8'h57) begin
         exp_wr.push_back({a, d});
         ref_mem[a] = d;
         exp_rsp.push_back(8'h4B);
      end else if (op == 8'h52) begin
         exp_rd.push_back(a);
         exp_rsp.push_back(ref_mem[a]);
      end else begin
         exp_rsp.push_back(8'h3F);
      end
   endtask

   task automatic frame_bytes(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                              input bit direct);
      logic [7:0] b[$];
      b.push_back(op);
      if (op == 8'h57 || op == 8'h52) b.push_back(a);
      if (op == 8'h57) b.push_back(d);
      foreach (b[i]) begin
         if (direct) rxq.push_back(b[i]);
         else src.push_back(b[i]);
      end
      rx_empty = (rxq.size() == 0);
      r_data   = rx_empty ? 8'h00 : rxq[0];
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound; i++) begin
         step();
         if (src.size() == 0 && rxq.size() == 0 && exp_rsp.size() == 0 && !busy) return;
      end
      chk("drain_timeout", 1, 0);
   endtask

   int t0, wr0, we0, re0, tmo0, pop0;
   logic [7:0] op, a, d;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      repeat (3) step();
      reset_n = 1'b1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_reg_addr", 32'(reg_addr), 0);
      chk("rst_reg_wdata", 32'(reg_wdata), 0);
      chk("rst_w_data", 32'(w_data), 0);
      chk("rst_strobes", 32'({rd_uart, wr_uart, reg_we, reg_re, timeout_err}), 0);

      // Back-to-back write
      pop0 = pop_cnt; t0 = cyc;
      model_frame(8'h57, 8'h10, 8'hA5);
      frame_bytes(8'h57, 8'h10, 8'hA5, 1);
      wait_idle(100);
      chk("wr_pops", pop_cnt - pop0, 3);
      chk("wr_last_pop_cyc", last_pop_cyc - t0, 2);
      chk("wr_we_cyc", last_we_cyc - t0, 3);
      chk("wr_resp_cyc", last_wr_cyc - t0, 4);
      chk("wr_busy_after", int'(busy), 0);

      // Read returning 3C
      mem[8'h22] = 8'h3C; ref_mem[8'h22] = 8'h3C;
      we0 = we_cnt; re0 = re_cnt; t0 = cyc;
      model_frame(8'h52, 8'h22, 8'h00);
      frame_bytes(8'h52, 8'h22, 8'h00, 1);
      wait_idle(100);
      chk("rd_re_count", re_cnt - re0, 1);
      chk("rd_no_we", we_cnt - we0, 0);
      chk("rd_re_cyc", last_re_cyc - t0, 2);
      chk("rd_resp_cyc", last_wr_cyc - t0, 4);

      // Unknown opcode, then a normal write
      pop0 = pop_cnt; t0 = cyc;
      model_frame(8'h00, 8'h00, 8'h00);
      frame_bytes(8'h00, 8'h00, 8'h00, 1);
      wait_idle(100);
      chk("unk_pops", pop_cnt - pop0, 1);
      chk("unk_resp_cyc", last_wr_cyc - t0, 1);
      model_frame(8'h57, 8'h01, 8'hFF);
      frame_bytes(8'h57, 8'h01, 8'hFF, 1);
      wait_idle(100);

      // Inter-byte timeout, then late bytes parse as fresh frames
      tmo0 = tmo_cnt; wr0 = wr_cnt; we0 = we_cnt; t0 = cyc;
      rxq.push_back(8'h57); rx_empty = 1'b0; r_data = 8'h57;
      repeat (25) step();
      chk("tmo_pulses", tmo_cnt - tmo0, 1);
      chk("tmo_cyc", last_tmo_cyc - t0, TMO);
      chk("tmo_no_resp", wr_cnt - wr0, 0);
      chk("tmo_no_we", we_cnt - we0, 0);
      chk("tmo_idle", int'(busy), 0);
      model_frame(8'h01, 8'h00, 8'h00);
      model_frame(8'hFF, 8'h00, 8'h00);
      rxq.push_back(8'h01); rxq.push_back(8'hFF); rx_empty = 1'b0; r_data = 8'h01;
      wait_idle(100);
      chk("late_bytes_resp", wr_cnt - wr0, 2);

      // Backpressure on TX
      tx_full = 1'b1; wr0 = wr_cnt; tmo0 = tmo_cnt;
      model_frame(8'h52, 8'h05, 8'h00);
      frame_bytes(8'h52, 8'h05, 8'h00, 1);
      repeat (50) step();
      chk("full_no_push", wr_cnt - wr0, 0);
      chk("full_no_tmo", tmo_cnt - tmo0, 0);
      chk("full_busy", int'(busy), 1);
      tx_full = 1'b0;
      wait_idle(100);
      chk("full_one_push", wr_cnt - wr0, 1);

      // Reset in GET_DATA aborts the frame
      wr0 = wr_cnt; we0 = we_cnt;
      rxq.push_back(8'h57); rxq.push_back(8'h10); rx_empty = 1'b0; r_data = 8'h57;
      step(); step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_strobes", 32'({rd_uart, wr_uart, reg_we, reg_re, timeout_err}), 0);
      chk("abort_regs", 32'({reg_addr, reg_wdata, w_data}), 0);
      repeat (5) step();
      chk("abort_no_resp", wr_cnt - wr0, 0);
      chk("abort_no_we", we_cnt - we0, 0);
      model_frame(8'h57, 8'h33, 8'h77);
      frame_bytes(8'h57, 8'h33, 8'h77, 1);
      wait_idle(100);
      chk("post_abort_we", we_cnt - we0, 1);

      // Random frames with short byte gaps and random TX backpressure
      rand_gaps = 1; rand_tx = 1; tmo0 = tmo_cnt;
      for (int n = 0; n < 40; n++) begin
         int k;
         k = int'($urandom_range(0, 9));
         a = 8'($urandom_range(0, 7));
         d = 8'($urandom);
         if (k < 4) op = 8'h57;
         else if (k < 8) op = 8'h52;
         else begin
            do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
         end
         model_frame(op, a, d);
         frame_bytes(op, a, d, 0);
      end
      wait_idle(5000);
      rand_tx = 0; tx_full = 1'b0;
      repeat (3) step();
      chk("rand_no_tmo", tmo_cnt - tmo0, 0);
      chk("left_rsp", exp_rsp.size(), 0);
      chk("left_wr", exp_wr.size(), 0);
      chk("left_rd", exp_rd.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Host-side command engine sitting on the far side of the uart block's FIFO interface. It pops received bytes from the RX FIFO and parses 2- or 3-byte command frames. It executes single-beat reads and writes on a simple internal register bus, then pushes a 1-byte response into the TX FIFO. This gives external UART masters register-level access to the SoC.

Parameters:
DW, 8, data/byte width (matches BITWIDTH)
AW, 8, register bus address width
TIMEOUT_CYCLES, 100000, max idle clk cycles between bytes of one frame before abort
CNT_W, 17, width of inter-byte timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
r_data  in  DW  RX FIFO head byte; valid whenever rx_empty=0 (first-word-fall-through)
rx_empty  in  1  RX FIFO empty
rd_uart  out  1  RX pop strobe, one cycle per byte
w_data  out  DW  byte to TX FIFO, valid with wr_uart
wr_uart  out  1  TX push strobe, one cycle per byte
tx_full  in  1  TX FIFO full
reg_addr  out  AW  register bus address
reg_wdata  out  DW  register write data
reg_we  out  1  write strobe, one cycle
reg_re  out  1  read strobe, one cycle
reg_rdata  in  DW  read data, valid exactly one cycle after reg_re
busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse on frame abort

Behaviour:
- Reset is synchronous, active-low. The clock and reset are one clk and one reset_n, sampled on posedge clk. Reset puts the FSM in IDLE and zeroes all outputs and registers. It aborts any frame mid-flight: no strobes and no response.
- Frame format:
  - 'W' (8'h57), addr, data: write; response 8'h4B ('K').
  - 'R' (8'h52), addr: read; response is the read byte.
  - Any other first byte: the byte is consumed and the response is 8'h3F ('?').
- States: IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_CAP, SEND.
- IDLE: if !rx_empty, assert rd_uart and latch r_data as opcode.
  - Next state is GET_ADDR for W/R.
  - Otherwise load resp=8'h3F and go to SEND.
- GET_ADDR: if !rx_empty, pop and latch reg_addr. W goes to GET_DATA; R goes to REG_RD.
- GET_DATA: if !rx_empty, pop, latch reg_wdata, go to REG_WR.
- REG_WR: reg_we=1 for one cycle, resp=8'h4B, go to SEND.
- REG_RD: reg_re=1 for one cycle, go to RD_CAP.
- RD_CAP: resp=reg_rdata, go to SEND.
- SEND: if !tx_full, assert wr_uart with w_data=resp, go to IDLE. Otherwise hold, with no timeout applied.
- Pop rule: rd_uart is registered or combinational from state plus !rx_empty. It is never asserted while rx_empty=1, and at most one pop per cycle. The data byte is captured in the same cycle as rd_uart.
- Push rule: wr_uart is never asserted while tx_full=1. w_data holds resp and is stable through SEND.
- Timeout: the counter runs in GET_ADDR and GET_DATA only.
  - It clears on every pop and on state entry, and increments each cycle with rx_empty=1.
  - At count == TIMEOUT_CYCLES-1 with rx_empty still 1: go to IDLE, pulse timeout_err, send no response, drop partial fields.
  - The counter saturates and never wraps.
- Latency with back-to-back bytes available and tx not full:
  - Write: pops at cycles 0, 1, 2; reg_we at 3; wr_uart at 4.
  - Read: pops at 0, 1; reg_re at 2; capture at 3; wr_uart at 4.
  - Unknown opcode: pop at 0; wr_uart at 1.
- A new frame may start in the cycle after wr_uart (IDLE). Throughput is one frame per 5 cycles maximum.
- reg_addr and reg_wdata hold their last values between transactions. Only the strobes are qualified.
- busy=0 only in IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - BITWIDTH=8 and SB_TICK constants (already project-wide).
  - Opcode constants OP_WR=8'h57, OP_RD=8'h52.
  - Response constants RSP_ACK=8'h4B, RSP_NAK=8'h3F.
  - The state enum typedef cmd_state_t.
- One natural sub-module: uart_cmd_timeout (clear/enable/saturating counter with terminal-count output). Everything else is a single FSM.

Test Plan:
- RX FIFO preloaded 57 10 A5, tx_full=0 -> pops on 3 consecutive cycles; reg_we pulse with reg_addr=8'h10, reg_wdata=8'hA5; then wr_uart with w_data=8'h4B; busy falls.
- RX preloaded 52 22, reg_rdata model returns 8'h3C the cycle after reg_re -> exactly one reg_re, no reg_we; wr_uart with w_data=8'h3C 2 cycles after reg_re.
- RX byte 8'h00 -> single pop, no reg strobes, wr_uart with w_data=8'h3F; the following frame 57 01 FF executes normally.
- TIMEOUT_CYCLES=20; send 57 then no bytes for 25 cycles -> timeout_err pulses once at cycle 20 after the pop, no reg_we, no wr_uart. Late bytes 01 FF are parsed as a new frame: 01 gives '?', FF gives '?'.
- Read with tx_full=1 held for 50 cycles -> FSM stays in SEND, no wr_uart, no timeout. Releasing tx_full gives exactly one wr_uart. rd_uart is never asserted while rx_empty=1 (assertion throughout).
- Assert reset_n=0 for one cycle during GET_DATA -> next cycle IDLE with all outputs 0, no reg_we or wr_uart from the aborted frame, and the next clean frame succeeds.
